ex_div: RTL and testbench

Iterative RV32M divide unit for DIV, DIVU, REM and REMU. It sits inside the execute stage, directly downstream of the ID/EX pipeline register, and consumes that register's operands and destination. It holds the front of the pipeline through the ctrl hold path while computing one quotient bit per cycle. It returns a one-cycle write-back result to the execute stage.

---
 rtl/ex_div_pkg.sv | 26 ++
 rtl/ex_div.sv | 141 ++++++++++++++
 tb/tb_ex_div.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ex_div_pkg.sv
// Shared encodings and reset constants for the RV32M iterative divider.
package ex_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg      = 5'b00000;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] MinInt       = 32'h8000_0000;

  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative RV32M DIV/DIVU/REM/REMU: one restoring step per cycle on operand
// magnitudes, sign fix-up at the end, single-cycle write-back pulse.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic [4:0]    rd_addr_i,
  input  logic          flush_i,
  output logic          busy_o,
  output logic          ready_o,
  output logic [DW-1:0] result_o,
  output logic [4:0]    rd_addr_o,
  output logic          reg_wen_o
);

  div_state_e    state_q, state_d;
  logic          rem_sel_q, rem_sel_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] dsr_q, dsr_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] result_q, result_d;
  logic [4:0]    count_q, count_d;
  logic [4:0]    rd_q, rd_d;

  logic          is_signed, a_neg, b_neg, div_zero, overflow, launch;
  logic [DW:0]   rem_shift;
  logic          sub_ok;
  logic [DW-1:0] rem_next, quo_next, quo_fix, rem_fix;

  assign is_signed = ~op_i[0];
  assign a_neg     = is_signed & dividend_i[DW-1];
  assign b_neg     = is_signed & divisor_i[DW-1];
  assign div_zero  = (divisor_i == '0);
  assign overflow  = is_signed & (dividend_i == MinInt) & (divisor_i == '1);
  assign launch    = (state_q == S_IDLE) & start_i & ~flush_i;

  // The dividend register doubles as the quotient: its MSB feeds the partial
  // remainder while the new quotient bit enters at the LSB.
  assign rem_shift = {rem_q, dvd_q[DW-1]};
  assign sub_ok    = (rem_shift >= {1'b0, dsr_q});
  assign rem_next  = sub_ok ? (rem_shift[DW-1:0] - dsr_q) : rem_shift[DW-1:0];
  assign quo_next  = {dvd_q[DW-2:0], sub_ok};
  assign quo_fix   = neg_if(quo_next, neg_quo_q);
  assign rem_fix   = neg_if(rem_next, neg_rem_q);

  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    result_d  = result_q;
    count_d   = count_q;
    rd_d      = rd_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          rem_sel_d = op_i[1];
          rd_d      = rd_addr_i;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dvd_d     = neg_if(dividend_i, a_neg);
          dsr_d     = neg_if(divisor_i, b_neg);
          rem_d     = '0;
          count_d   = '0;
          if (div_zero) begin
            result_d = op_i[1] ? dividend_i : '1;
            state_d  = S_DONE;
          end else if (overflow) begin
            result_d = op_i[1] ? ZeroWord : MinInt;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          dvd_d   = quo_next;
          rem_d   = rem_next;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            result_d = rem_sel_q ? rem_fix : quo_fix;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        result_d = ZeroWord;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= ZeroWord;
      dsr_q     <= ZeroWord;
      rem_q     <= ZeroWord;
      result_q  <= ZeroWord;
      count_q   <= '0;
      rd_q      <= ZeroReg;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
    end
  end

  assign busy_o    = launch | (state_q == S_CALC);
  assign ready_o   = (state_q == S_DONE) & ~flush_i;
  assign result_o  = ready_o ? result_q : ZeroWord;
  assign rd_addr_o = rd_q;
  assign reg_wen_o = ready_o ? 1'b1 : WriteDisable;

endmodule

// File: tb/tb_ex_div.sv
// Randomized and directed checks of ex_div against an arithmetic reference.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ex_div #(.DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .reg_wen_o  (reg_wen_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Launch one op and follow it to write-back; inj_cyc issues a stray start
  // in that cycle, flush_cyc cancels the op in that cycle (0 = neither).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int inj_cyc, input int flush_cyc);
    int cyc, busy_cnt, exp_lat;
    logic got_ready;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd; flush_i = 1'b0;
    #1;
    check("busy_launch", 32'(busy_o), 32'd1);
    exp_lat   = is_fast(op, a, b) ? 1 : 33;
    busy_cnt  = 1;
    cyc       = 0;
    got_ready = 1'b0;
    while (!got_ready && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start_i = 1'b0;
      flush_i = 1'b0;
      if (cyc == inj_cyc) begin
        start_i = 1'b1; op_i = ~op; dividend_i = $urandom; divisor_i = 32'd1; rd_addr_i = ~rd;
      end
      if (cyc == flush_cyc) flush_i = 1'b1;
      #1;
      if (flush_cyc != 0 && cyc == flush_cyc) begin
        check("ready_flush", 32'(ready_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        #1;
        check("busy_after_flush", 32'(busy_o), 32'd0);
        check("ready_after_flush", 32'(ready_o), 32'd0);
        return;
      end
      if (ready_o) got_ready = 1'b1;
      else if (busy_o) busy_cnt++;
    end
    check("ready_seen", 32'(got_ready), 32'd1);
    if (!got_ready) return;
    check("latency", 32'(cyc), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
    check("busy_in_done", 32'(busy_o), 32'd0);
    check("result", result_o, ref_div(op, a, b));
    check("rd_addr", 32'(rd_addr_o), 32'(rd));
    check("reg_wen", 32'(reg_wen_o), 32'd1);
    @(posedge clk); #2;
    check("ready_one_cycle", 32'(ready_o), 32'd0);
    check("result_idle_zero", result_o, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; dividend_i = '0; divisor_i = '0;
    rd_addr_i = '0; flush_i = 1'b0;
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", 32'(rd_addr_o), 32'd0);
    check("rst_wen", 32'(reg_wen_o), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 5'd9, 0, 0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd16, 5'd5, 0, 0);
    run_op(2'b00, 32'd5, 32'd0, 5'd6, 0, 0);
    run_op(2'b11, 32'd5, 32'd0, 5'd7, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0);

    run_op(2'b01, 32'd100, 32'd7, 5'd12, 0, 10);
    run_op(2'b01, 32'd9, 32'd3, 5'd13, 0, 0);

    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd14, 5, 0);

    // Asynchronous reset in the middle of a calculation.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; rd_addr_i = 5'd15;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_rd", 32'(rd_addr_o), 32'd0);
    check("midrst_wen", 32'(reg_wen_o), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    check("postrst_busy", 32'(busy_o), 32'd0);
    run_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd16, 0, 0);

    for (int unsigned i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int unsigned mode;
      op   = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3, 4: b = b >> $urandom_range(8, 28);
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom_range(0, 31)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
